sme_axis_ingress_adapter: RTL

Converts an AXI-Stream packet stream into the Avalon-ST style interface consumed by string_matcher: byte-order reversal, tkeep-to-empty conversion, padding of invalid bytes, and tlast-based SOP generation. Also keeps a per-channel history of the last TAIL_BYTES stream bytes so the SME can match patterns that span packets of the same flow. A 2-entry skid buffer keeps the input ready a registered signal. Sits between the core's packet DMA and string_matcher.

---
 rtl/sme_adapter_pkg.sv | 23 ++
 rtl/sme_skid_buffer.sv | 45 ++++
 rtl/sme_axis_ingress_adapter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sme_adapter_pkg.sv
// Shared definitions for the SME ingress adapter: pad default, error causes, keep decoding.
package sme_adapter_pkg;

   localparam logic [7:0] PAD_BYTE_DEFAULT = 8'hFF;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_NONCONTIG,
      ERR_PARTIAL,
      ERR_ZERO_KEEP
   } err_cause_t;

   // Index of the first cleared keep bit; equals the popcount when keep is LSB-contiguous.
   function automatic int unsigned keep_len(input logic [63:0] keep, input int unsigned nbytes);
      int unsigned len;
      len = nbytes;
      for (int i = 63; i >= 0; i--) begin
         if (i < int'(nbytes) && !keep[i]) len = $unsigned(i);
      end
      return len;
   endfunction

endpackage

// File: rtl/sme_skid_buffer.sv
// Two-entry valid/ready register slice; push_rdy is registered and drops only when both entries are held.
module sme_skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             push_vld,
   output logic             push_rdy,
   output logic [WIDTH-1:0] pop_dat,
   output logic             pop_vld,
   input  logic             pop_rdy
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr, rd_ptr;
   logic [1:0]       count, count_n;
   logic             push, pop;

   assign push    = push_vld & push_rdy;
   assign pop     = pop_vld & pop_rdy;
   assign pop_vld = (count != 2'd0);
   assign pop_dat = mem[rd_ptr];
   assign count_n = count + 2'(push) - 2'(pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0]   <= '0;
         mem[1]   <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count    <= 2'd0;
         push_rdy <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count    <= count_n;
         push_rdy <= (count_n != 2'd2);
      end
   end

endmodule

// File: rtl/sme_axis_ingress_adapter.sv
// AXI-Stream to string_matcher packet adapter: keep->empty, lane padding, byte reversal,
// SOP tracking and per-channel tail history; one cycle to output through a 2-entry skid.
module sme_axis_ingress_adapter
   import sme_adapter_pkg::*;
#(
   parameter int         BYTE_COUNT = 16,
   parameter int         TAIL_BYTES = 7,
   parameter int         CHANNELS   = 4,
   parameter bit         REVERSE    = 1'b1,
   parameter logic [7:0] PAD_BYTE   = PAD_BYTE_DEFAULT
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [BYTE_COUNT*8-1:0]       s_axis_tdata,
   input  logic [BYTE_COUNT-1:0]         s_axis_tkeep,
   input  logic [$clog2(CHANNELS)-1:0]   s_axis_tdest,
   input  logic                          s_axis_tvalid,
   input  logic                          s_axis_tlast,
   output logic                          s_axis_tready,
   output logic [BYTE_COUNT*8-1:0]       out_pkt_data,
   output logic [$clog2(BYTE_COUNT)-1:0] out_pkt_empty,
   output logic                          out_pkt_valid,
   output logic                          out_pkt_sop,
   output logic                          out_pkt_eop,
   output logic [$clog2(CHANNELS)-1:0]   out_pkt_chan,
   input  logic                          out_pkt_ready,
   output logic [TAIL_BYTES*8-1:0]       tail_data,
   output logic [$clog2(CHANNELS)-1:0]   tail_chan,
   output logic                          tail_valid,
   input  logic                          tail_clr,
   input  logic [$clog2(CHANNELS)-1:0]   tail_clr_chan,
   output logic [15:0]                   proto_err_cnt
);

   localparam int KW = $clog2(BYTE_COUNT);
   localparam int CW = $clog2(CHANNELS);
   localparam int NW = KW + 1;
   localparam int DW = BYTE_COUNT * 8;
   localparam int HW = TAIL_BYTES * 8;
   localparam int PW = DW + KW + 2 + CW;

   logic                  in_pkt;
   logic [CW-1:0]         pkt_chan, beat_chan;
   logic [NW-1:0]         n;
   logic [BYTE_COUNT-1:0] mask;
   logic [DW-1:0]         pad_data, rev_data;
   logic [KW-1:0]         empty;
   err_cause_t            cause;
   logic                  accept, drop, sop, push_vld;
   logic [HW-1:0]         hist [CHANNELS];
   logic [HW-1:0]         base_hist, new_hist;
   logic [HW+DW-1:0]      joined;
   logic [PW-1:0]         push_dat, pop_dat;

   always_comb begin
      n = NW'(keep_len(64'(s_axis_tkeep), BYTE_COUNT));
      mask = '0;
      pad_data = '0;
      rev_data = '0;
      for (int i = 0; i < BYTE_COUNT; i++) begin
         mask[i] = (NW'(i) < n);
         pad_data[i*8 +: 8] = mask[i] ? s_axis_tdata[i*8 +: 8] : PAD_BYTE;
         rev_data[(BYTE_COUNT-1-i)*8 +: 8] = pad_data[i*8 +: 8];
      end

      if (s_axis_tkeep == '0)                      cause = ERR_ZERO_KEEP;
      else if (s_axis_tkeep != mask)               cause = ERR_NONCONTIG;
      else if (!s_axis_tlast && !(&s_axis_tkeep))  cause = ERR_PARTIAL;
      else                                         cause = ERR_NONE;

      drop      = (s_axis_tkeep == '0) && !s_axis_tlast;
      accept    = s_axis_tvalid && s_axis_tready;
      push_vld  = s_axis_tvalid && !drop;
      sop       = !in_pkt;
      beat_chan = in_pkt ? pkt_chan : s_axis_tdest;

      // An all-zero keep on EOP cannot encode BYTE_COUNT empty bytes, so it saturates one lower.
      if (!s_axis_tlast)   empty = '0;
      else if (n == '0)    empty = KW'(BYTE_COUNT - 1);
      else                 empty = KW'(BYTE_COUNT - int'(n));

      // rev_data holds the beat in stream order, so the history is a plain right shift by the unused lanes.
      base_hist = (tail_clr && tail_clr_chan == beat_chan) ? {TAIL_BYTES{PAD_BYTE}} : hist[beat_chan];
      joined    = {base_hist, rev_data};
      new_hist  = HW'(joined >> ((BYTE_COUNT - int'(n)) * 8));
   end

   assign push_dat = {(REVERSE ? rev_data : pad_data), empty, sop, s_axis_tlast, beat_chan};
   assign {out_pkt_data, out_pkt_empty, out_pkt_sop, out_pkt_eop, out_pkt_chan} = pop_dat;

   sme_skid_buffer #(.WIDTH(PW)) u_skid (
      .clk      (clk),
      .rst      (rst),
      .push_dat (push_dat),
      .push_vld (push_vld),
      .push_rdy (s_axis_tready),
      .pop_dat  (pop_dat),
      .pop_vld  (out_pkt_valid),
      .pop_rdy  (out_pkt_ready)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         in_pkt        <= 1'b0;
         pkt_chan      <= '0;
         proto_err_cnt <= 16'd0;
         tail_valid    <= 1'b0;
         tail_data     <= {TAIL_BYTES{PAD_BYTE}};
         tail_chan     <= '0;
         for (int c = 0; c < CHANNELS; c++) hist[c] <= {TAIL_BYTES{PAD_BYTE}};
      end else begin
         tail_valid <= 1'b0;
         if (tail_clr) hist[tail_clr_chan] <= {TAIL_BYTES{PAD_BYTE}};
         if (accept) begin
            if (cause != ERR_NONE && proto_err_cnt != 16'hFFFF)
               proto_err_cnt <= proto_err_cnt + 16'd1;
            if (!drop) begin
               hist[beat_chan] <= new_hist;
               if (sop) pkt_chan <= s_axis_tdest;
               in_pkt <= !s_axis_tlast;
               if (s_axis_tlast) begin
                  tail_valid <= 1'b1;
                  tail_data  <= new_hist;
                  tail_chan  <= beat_chan;
               end
            end
         end
      end
   end

endmodule
